cpu_header_strip: RTL
=====================

CPU_HEADER_STRIP -- requirements
Module: cpu_header_strip

Interface
REQ-001 SHALL have parameter C_DATA_WIDTH, default 256, AXIS data width in bits.
REQ-002 SHALL have parameter C_TUSER_WIDTH, default 128, header width in bits; HDR_BYTES = C_TUSER_WIDTH/8 = 16.
REQ-003 SHALL have ports:
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- s_axis_tdata  in  C_DATA_WIDTH  packet with CPU header in bytes 0..15 of beat 0.
- s_axis_tkeep  in  C_DATA_WIDTH/8  byte enables, LSB-contiguous.
- s_axis_tvalid  in  1  input valid.
- s_axis_tlast  in  1  last input beat.
- s_axis_tready  out  1  input ready.
- m_axis_tdata  out  C_DATA_WIDTH  payload realigned to byte 0.
- m_axis_tuser  out  C_TUSER_WIDTH  extracted header, constant for all beats of a packet.
- m_axis_tkeep  out  C_DATA_WIDTH/8  output byte enables.
- m_axis_tvalid  out  1  output valid.
- m_axis_tlast  out  1  last output beat.
- m_axis_tready  in  1  output ready.
- runt_drop  out  1  one-cycle pulse when a packet is dropped.

Function
REQ-004 SHALL use FSM states S_HDR, S_BODY, S_TAIL; transfer = tvalid && tready.
REQ-005 S_HDR: s_axis_tready=1; on transfer latch hdr = tdata[127:0], carry = tdata[255:128], carry_keep = tkeep[31:16].
REQ-006 S_HDR transitions: tlast=0 -> S_BODY; tlast=1 with tkeep[31:16]!=0 -> S_TAIL; tlast=1 with tkeep[31:16]==0 -> stay S_HDR, drop, pulse runt_drop next cycle.
REQ-007 S_BODY: s_axis_tready = !m_axis_tvalid || m_axis_tready; each transfer loads output register with tdata={in[127:0],carry}, tkeep={in_keep[15:0],carry_keep}, tuser=hdr, then updates carry/carry_keep from in upper half.
REQ-008 S_BODY tlast transfer: in_keep[31:16]==0 -> output tlast=1, go S_HDR; else output tlast=0, go S_TAIL.
REQ-009 S_TAIL: s_axis_tready=0; when output register free, emit tdata={128'h0,carry}, tkeep={16'h0,carry_keep}, tlast=1, go S_HDR.
REQ-010 Output register SHALL hold tdata/tkeep/tuser/tlast stable while m_axis_tvalid && !m_axis_tready.
REQ-011 Latency: first output beat valid one cycle after second input beat (or S_TAIL entry) is accepted.
REQ-012 Zero-bubble throughput in S_BODY with m_axis_tready held high; one extra cycle per packet only when S_TAIL is used.
REQ-013 Header latch for a new packet in S_HDR SHALL NOT disturb a pending output beat of the previous packet.

Reset
REQ-014 On rst: state=S_HDR, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata/tuser/tkeep=0, carry=0, runt_drop=0, counters=0.
REQ-015 Reset mid-packet SHALL discard the partial packet; the next s_axis beat is treated as a header.

Configuration
REQ-016 With CPU_HEADER_STRIP_STATS_EN defined: 32-bit outputs pkt_cnt (incremented on each m_axis tlast transfer) and runt_cnt (incremented on each runt_drop), both saturating at 32'hFFFFFFFF; without it these ports and registers do not exist.

Structure
REQ-017 Package cpu_header_pkg SHALL hold HDR_BYTES, default widths and the FSM state typedef.
REQ-018 The output holding register SHALL be sub-module cpu_header_out_reg; FSM and realignment stay in the top.

Verification
REQ-019 3-beat packet, tuser field 128'hAAAA..., last tkeep 32'h0000FFFF, m_axis_tready=1 -> 2 output beats, tuser=128'hAAAA... on both, last tkeep 32'hFFFFFFFF, tlast on beat 2.
REQ-020 3-beat packet, last tkeep 32'hFFFFFFFF -> 3 output beats (S_TAIL), final tkeep 32'h0000FFFF, s_axis_tready low 1 cycle.
REQ-021 1-beat packet with tkeep 32'h0000FFFF -> no output, runt_drop pulses once; next packet passes intact.
REQ-022 Back-to-back packets with headers 128'hBBBB... and 128'hCCCC..., m_axis_tready toggling every 2 cycles -> no data loss/duplication, m_axis_tuser switches exactly at packet boundary, outputs stable while stalled.
REQ-023 rst asserted after beat 2 of a 4-beat packet -> m_axis_tvalid=0 next cycle; following packet's header extracted correctly.
REQ-024 With CPU_HEADER_STRIP_STATS_EN: 5 good + 2 runt packets -> pkt_cnt=5, runt_cnt=2.

Source files
------------

// File: rtl/cpu_header_pkg.sv
// -----------------------------------------------------------------------------
// cpu_header_pkg
// Shared definitions for the CPU header strip block: header size, default
// AXI-Stream widths and the FSM state encoding.
// -----------------------------------------------------------------------------
package cpu_header_pkg;

    // Size of the CPU header carried at the front of every packet.
    localparam int HDR_BYTES       = 16;

    // Default stream widths: 32-byte data bus, 128-bit header on tuser.
    localparam int DEF_DATA_WIDTH  = 256;
    localparam int DEF_TUSER_WIDTH = HDR_BYTES * 8;

    // S_HDR  : waiting for beat 0 of a packet (holds the header)
    // S_BODY : forwarding realigned payload beats
    // S_TAIL : flushing the carried upper half after the last input beat
    typedef enum logic [1:0] {
        S_HDR  = 2'd0,
        S_BODY = 2'd1,
        S_TAIL = 2'd2
    } state_e;

endpackage : cpu_header_pkg

// File: rtl/cpu_header_strip_if.sv
// -----------------------------------------------------------------------------
// cpu_header_strip_if
// AXI-Stream bundle used on both sides of cpu_header_strip.
//   tdata  : C_DATA_WIDTH bits of payload
//   tkeep  : byte enables, LSB-contiguous
//   tuser  : C_TUSER_WIDTH sideband (extracted header on the output side)
//   tvalid : beat valid (source)
//   tlast  : last beat of packet (source)
//   tready : sink ready
// Modports: master = stream source, slave = stream sink.
// -----------------------------------------------------------------------------
interface cpu_header_strip_if
    import cpu_header_pkg::*;
#(
    parameter int C_DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int C_TUSER_WIDTH = DEF_TUSER_WIDTH
);

    logic [C_DATA_WIDTH-1:0]   tdata;
    logic [C_DATA_WIDTH/8-1:0] tkeep;
    logic [C_TUSER_WIDTH-1:0]  tuser;
    logic                      tvalid;
    logic                      tlast;
    logic                      tready;

    modport master (
        output tdata, tkeep, tuser, tvalid, tlast,
        input  tready
    );

    modport slave (
        input  tdata, tkeep, tuser, tvalid, tlast,
        output tready
    );

endinterface : cpu_header_strip_if

// File: rtl/cpu_header_out_reg.sv
// -----------------------------------------------------------------------------
// cpu_header_out_reg
// Single-entry AXI-Stream output holding register. A beat presented on the
// *_i inputs with load_i is captured and held on m_axis until the sink takes
// it; while m_axis.tvalid && !m_axis.tready the held beat never changes.
//
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   load_i     : capture tdata_i/tkeep_i/tuser_i/tlast_i this cycle
//                (caller only asserts it while free_o is high)
//   free_o     : register is empty or is being drained this cycle
//   m_axis     : output stream (master modport)
// -----------------------------------------------------------------------------
module cpu_header_out_reg
    import cpu_header_pkg::*;
#(
    parameter int C_DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int C_TUSER_WIDTH = DEF_TUSER_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load_i,
    input  logic [C_DATA_WIDTH-1:0]   tdata_i,
    input  logic [C_DATA_WIDTH/8-1:0] tkeep_i,
    input  logic [C_TUSER_WIDTH-1:0]  tuser_i,
    input  logic                      tlast_i,
    output logic                      free_o,
    cpu_header_strip_if.master        m_axis
);

    logic [C_DATA_WIDTH-1:0]   tdata_q;
    logic [C_DATA_WIDTH/8-1:0] tkeep_q;
    logic [C_TUSER_WIDTH-1:0]  tuser_q;
    logic                      tlast_q;
    logic                      tvalid_q;

    // A new beat may enter whenever the current one is absent or leaving.
    assign free_o = !tvalid_q || m_axis.tready;

    // NOTE: sequential state is written only with non-blocking assignments so
    // every register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the wide data/user registers are reset too, because the
            // output bus must read as zero coming out of reset.
            tdata_q  <= '0;
            tkeep_q  <= '0;
            tuser_q  <= '0;
            tlast_q  <= 1'b0;
            tvalid_q <= 1'b0;
        end else if (load_i) begin
            tdata_q  <= tdata_i;
            tkeep_q  <= tkeep_i;
            tuser_q  <= tuser_i;
            tlast_q  <= tlast_i;
            tvalid_q <= 1'b1;
        end else if (m_axis.tready) begin
            tvalid_q <= 1'b0;
        end
    end

    assign m_axis.tdata  = tdata_q;
    assign m_axis.tkeep  = tkeep_q;
    assign m_axis.tuser  = tuser_q;
    assign m_axis.tlast  = tlast_q;
    assign m_axis.tvalid = tvalid_q;

endmodule : cpu_header_out_reg

// File: rtl/cpu_header_strip.sv
// -----------------------------------------------------------------------------
// cpu_header_strip
// Removes the 16-byte CPU header from the front of each AXI-Stream packet,
// presents it on m_axis.tuser for every beat of that packet, and realigns the
// remaining payload so it starts at byte 0. Each output beat is the carried
// upper half of the previous input beat joined with the lower half of the
// current one. If the last input beat has valid upper-half bytes, one extra
// tail beat flushes them. A packet whose only beat holds nothing beyond the
// header is dropped and flagged on runt_drop.
//
// The data bus is split at C_TUSER_WIDTH: the lower C_TUSER_WIDTH bits of beat
// 0 are the header, the rest is carried. The default 256/128 split is the
// intended configuration.
//
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   s_axis     : input stream, header in bytes 0..15 of beat 0 (tuser unused)
//   m_axis     : output stream, realigned payload, header on tuser
//   runt_drop  : one-cycle pulse the cycle after a runt packet is discarded
//   pkt_cnt    : saturating count of output packets   (CPU_HEADER_STRIP_STATS_EN)
//   runt_cnt   : saturating count of dropped runts    (CPU_HEADER_STRIP_STATS_EN)
//
// Build option: define CPU_HEADER_STRIP_STATS_EN to add pkt_cnt/runt_cnt.
// -----------------------------------------------------------------------------
module cpu_header_strip
    import cpu_header_pkg::*;
#(
    parameter int C_DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int C_TUSER_WIDTH = DEF_TUSER_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    cpu_header_strip_if.slave  s_axis,
    cpu_header_strip_if.master m_axis,
    output logic               runt_drop
`ifdef CPU_HEADER_STRIP_STATS_EN
    ,
    output logic [31:0]        pkt_cnt,
    output logic [31:0]        runt_cnt
`endif
);

    localparam int KW  = C_DATA_WIDTH / 8;           // keep bits per beat
    localparam int HW  = C_TUSER_WIDTH;              // header / low-half width
    localparam int HKW = HW / 8;                     // keep bits in low half
    localparam int CW  = C_DATA_WIDTH - HW;          // carried upper-half width
    localparam int CKW = CW / 8;                     // keep bits in carry

    state_e          state_q;
    logic [HW-1:0]   hdr_q;
    logic [CW-1:0]   carry_q;
    logic [CKW-1:0]  carry_keep_q;
    logic            runt_drop_q;

    // Input beat split into the half that completes the current output beat
    // and the half that is carried into the next one.
    logic [HW-1:0]   in_lo;
    logic [CW-1:0]   in_hi;
    logic [HKW-1:0]  keep_lo;
    logic [CKW-1:0]  keep_hi;
    logic            hi_empty;

    assign in_lo    = s_axis.tdata[HW-1:0];
    assign in_hi    = s_axis.tdata[C_DATA_WIDTH-1:HW];
    assign keep_lo  = s_axis.tkeep[HKW-1:0];
    assign keep_hi  = s_axis.tkeep[KW-1:HKW];
    assign hi_empty = (keep_hi == '0);

    logic            out_free;
    logic            s_ready;
    logic            s_xfer;

    // Header beats never touch the output register, so S_HDR can always
    // accept; a pending beat of the previous packet stays untouched.
    always_comb begin
        s_ready = 1'b0;
        case (state_q)
            S_HDR:   s_ready = 1'b1;
            S_BODY:  s_ready = out_free;
            default: s_ready = 1'b0;
        endcase
    end

    assign s_axis.tready = s_ready;
    assign s_xfer        = s_axis.tvalid && s_ready;

    // Next beat for the output register.
    logic                    load_d;
    logic [C_DATA_WIDTH-1:0] tdata_d;
    logic [KW-1:0]           tkeep_d;
    logic                    tlast_d;

    // NOTE: every signal assigned in this block gets a default first, so no
    // path through the case leaves it unassigned and no latch is inferred.
    always_comb begin
        load_d  = 1'b0;
        tdata_d = {in_lo, carry_q};
        tkeep_d = {keep_lo, carry_keep_q};
        tlast_d = s_axis.tlast && hi_empty;
        case (state_q)
            S_BODY: begin
                load_d = s_xfer;
            end
            S_TAIL: begin
                load_d  = out_free;
                tdata_d = {{HW{1'b0}}, carry_q};
                tkeep_d = {{HKW{1'b0}}, carry_keep_q};
                tlast_d = 1'b1;
            end
            default: begin
                load_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_HDR;
            hdr_q        <= '0;
            carry_q      <= '0;
            carry_keep_q <= '0;
            runt_drop_q  <= 1'b0;
        end else begin
            runt_drop_q <= 1'b0;
            case (state_q)
                S_HDR: begin
                    if (s_xfer) begin
                        hdr_q        <= in_lo;
                        carry_q      <= in_hi;
                        carry_keep_q <= keep_hi;
                        if (!s_axis.tlast) begin
                            state_q <= S_BODY;
                        end else if (!hi_empty) begin
                            state_q <= S_TAIL;
                        end else begin
                            // Header-only packet: nothing to forward.
                            runt_drop_q <= 1'b1;
                        end
                    end
                end
                S_BODY: begin
                    if (s_xfer) begin
                        carry_q      <= in_hi;
                        carry_keep_q <= keep_hi;
                        if (s_axis.tlast) begin
                            state_q <= hi_empty ? S_HDR : S_TAIL;
                        end
                    end
                end
                S_TAIL: begin
                    if (out_free) begin
                        state_q <= S_HDR;
                    end
                end
                default: begin
                    state_q <= S_HDR;
                end
            endcase
        end
    end

    assign runt_drop = runt_drop_q;

    cpu_header_out_reg #(
        .C_DATA_WIDTH  (C_DATA_WIDTH),
        .C_TUSER_WIDTH (C_TUSER_WIDTH)
    ) u_out_reg (
        .clk     (clk),
        .rst     (rst),
        .load_i  (load_d),
        .tdata_i (tdata_d),
        .tkeep_i (tkeep_d),
        .tuser_i (hdr_q),
        .tlast_i (tlast_d),
        .free_o  (out_free),
        .m_axis  (m_axis)
    );

`ifdef CPU_HEADER_STRIP_STATS_EN
    logic [31:0] pkt_cnt_q;
    logic [31:0] runt_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_cnt_q  <= '0;
            runt_cnt_q <= '0;
        end else begin
            if (m_axis.tvalid && m_axis.tready && m_axis.tlast && (pkt_cnt_q != '1)) begin
                pkt_cnt_q <= pkt_cnt_q + 32'd1;
            end
            if (runt_drop_q && (runt_cnt_q != '1)) begin
                runt_cnt_q <= runt_cnt_q + 32'd1;
            end
        end
    end

    assign pkt_cnt  = pkt_cnt_q;
    assign runt_cnt = runt_cnt_q;
`endif

endmodule : cpu_header_strip
